// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run-control block.
package core_run_pkg;

   // Run-control state machine states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } run_state_e;

   // Latched termination status codes.
   localparam logic [1:0] ST_NONE    = 2'd0;
   localparam logic [1:0] ST_FINISH  = 2'd1;
   localparam logic [1:0] ST_OVF     = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   // Opcode field value that ends a run, unless overridden.
   localparam logic [9:0] DEF_FINISH_OPC = 10'h001;

   // Resolve simultaneous termination events: finish beats overflow beats timeout.
   function automatic logic [1:0] status_pick(input logic fin, input logic ovf);
      if (fin) return ST_FINISH;
      if (ovf) return ST_OVF;
      return ST_TIMEOUT;
   endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Signal bundle between the run controller and the core/stimulus side.
interface core_run_ctrl_if #(
   parameter int unsigned N_IRQ     = 4,
   parameter int unsigned OP_W      = 32,
   parameter int unsigned TIMEOUT_W = 10
);
   logic                 start;
   logic                 ps_idle;
   logic [OP_W-1:0]      pm_op;
   logic                 pcstk_ovf;
   logic [N_IRQ-1:0]     irq_mask;
   logic [N_IRQ-1:0]     interrupt;
   logic                 stallb_en;
   logic                 done;
   logic [1:0]           status;
   logic [TIMEOUT_W-1:0] cycle_cnt;

   // Core / bench side: issues start and reports core state.
   modport master (
      output start, ps_idle, pm_op, pcstk_ovf, irq_mask,
      input  interrupt, stallb_en, done, status, cycle_cnt
   );

   // Run controller side.
   modport slave (
      input  start, ps_idle, pm_op, pcstk_ovf, irq_mask,
      output interrupt, stallb_en, done, status, cycle_cnt
   );
endinterface

// File: rtl/run_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running from reset.
module run_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);
   logic [7:0] q_q;
   logic       fb;

   assign fb = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];

   // Shift every cycle; SEED must be nonzero or the register locks up.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_q <= SEED;
      else        q_q <= {q_q[6:0], fb};
   end

   assign q = q_q;
endmodule

// File: rtl/core_run_ctrl.sv
// Run control and watchdog for core bring-up: start/run/drain/done sequencing,
// round-robin random-delay interrupts, stall duty cycle and termination status.
module core_run_ctrl
   import core_run_pkg::*;
#(
   parameter int unsigned    N_IRQ      = 4,
   parameter int unsigned    OP_W       = 32,
   parameter int unsigned    OPC_W      = 10,
   parameter logic [OPC_W-1:0] FINISH_OPC = DEF_FINISH_OPC,
   parameter int unsigned    TIMEOUT_W  = 10,
   parameter int unsigned    DELAY_W    = 3,
   parameter int unsigned    STALL_HI   = 4,
   parameter int unsigned    STALL_LO   = 3,
   parameter int unsigned    DRAIN_CYC  = 10,
   parameter logic [7:0]     LFSR_SEED  = 8'hA5
) (
   input logic             clk,
   input logic             reset,
   core_run_ctrl_if.slave  bus
);
   localparam int unsigned PTR_W   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam int unsigned STALL_P = STALL_HI + STALL_LO;
   localparam int unsigned STALL_W = (STALL_P > 1) ? $clog2(STALL_P) : 1;
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);

   run_state_e           state_q, state_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic [1:0]           status_q, status_d;
   logic                 done_q, done_d;
   logic [N_IRQ-1:0]     irq_q, irq_d;
   logic                 stallb_q, stallb_d;
   logic [DELAY_W-1:0]   dly_q, dly_d;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [PTR_W-1:0]     rr_q, rr_d;

   logic [7:0]           lfsr_q;
   logic                 ev_fin, ev_ovf, ev_tmo, term;
   logic                 sel_vld;
   logic [PTR_W-1:0]     sel_idx, cand, rr_nxt;
   logic                 unused_bits;

   run_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign ev_fin = (bus.pm_op[OP_W-1 -: OPC_W] == FINISH_OPC);
   assign ev_ovf = bus.pcstk_ovf;
   assign ev_tmo = &cnt_q;
   assign term   = ev_fin | ev_ovf | ev_tmo;

   assign unused_bits = ^{lfsr_q[7:DELAY_W], bus.pm_op[OP_W-OPC_W-1:0]};

   // Pick the first enabled channel at or after the round-robin pointer.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         cand = PTR_W'((32'(rr_q) + i) % N_IRQ);
         if (!sel_vld && bus.irq_mask[cand]) begin
            sel_vld = 1'b1;
            sel_idx = cand;
         end
      end
      rr_nxt = (sel_idx == PTR_W'(N_IRQ - 1)) ? '0 : sel_idx + 1'b1;
   end

   // Next-state and registered-output logic for the run sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      status_d    = status_q;
      done_d      = done_q;
      irq_d       = '0;
      stallb_d    = 1'b1;
      dly_d       = dly_q;
      stall_cnt_d = stall_cnt_q;
      drain_cnt_d = drain_cnt_q;
      rr_d        = rr_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d     = RUN;
               cnt_d       = '0;
               status_d    = ST_NONE;
               done_d      = 1'b0;
               dly_d       = '0;
               stall_cnt_d = '0;
            end
         end
         RUN: begin
            // Saturating: all-ones is itself the timeout event.
            if (!ev_tmo) cnt_d = cnt_q + 1'b1;
            if (term) begin
               state_d     = DRAIN;
               status_d    = status_pick(ev_fin, ev_ovf);
               drain_cnt_d = '0;
            end else begin
               stall_cnt_d = (stall_cnt_q == STALL_W'(STALL_P - 1)) ? '0 : stall_cnt_q + 1'b1;
               stallb_d    = (32'(stall_cnt_d) < STALL_HI);
               if (bus.ps_idle) begin
                  if (dly_q == '0) begin
                     // Reload even when every channel is masked.
                     dly_d = lfsr_q[DELAY_W-1:0];
                     if (sel_vld) begin
                        irq_d = N_IRQ'(1) << sel_idx;
                        rr_d  = rr_nxt;
                     end
                  end else begin
                     dly_d = dly_q - 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any run with no drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         status_q    <= ST_NONE;
         done_q      <= 1'b0;
         irq_q       <= '0;
         stallb_q    <= 1'b1;
         dly_q       <= '0;
         stall_cnt_q <= '0;
         drain_cnt_q <= '0;
         rr_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         status_q    <= status_d;
         done_q      <= done_d;
         irq_q       <= irq_d;
         stallb_q    <= stallb_d;
         dly_q       <= dly_d;
         stall_cnt_q <= stall_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         rr_q        <= rr_d;
      end
   end

   assign bus.interrupt = irq_q;
   assign bus.stallb_en = stallb_q;
   assign bus.done      = done_q;
   assign bus.status    = status_q;
   assign bus.cycle_cnt = cnt_q;
endmodule
